ansi_param_fifo: RTL and testbench
==================================

Name: ansi_param_fifo

Overview:
- Parametrised successor to the ANSI-header pass-through blocks: a synchronous first-word-fall-through FIFO, WIDTH bits wide and DEPTH entries deep.
- Valid/ready handshake on both sides, plus occupancy, status flags and a synchronous flush.
- Internal widths are derived localparams in the ANSI parameter header.
- Sits between producer/consumer stages that need elastic buffering in the same clock domain.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of storage entries (>=2; not required to be a power of two).
- ADDR_W (localparam), $clog2(DEPTH), read/write pointer width.
- CNT_W (localparam), $clog2(DEPTH+1), occupancy counter width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush; empties FIFO, higher priority than push/pop.
- in_data  input  WIDTH  write data.
- in_valid  input  1  producer has data.
- in_ready  output  1  FIFO can accept; equals !full.
- out_data  output  WIDTH  head-of-queue data, valid when out_valid=1.
- out_valid  output  1  FIFO non-empty; equals !empty.
- out_ready  input  1  consumer accepts head.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky: set when in_valid=1 while full=1.

Behaviour:
- Reset (RST_N low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, overflow=0, empty=1, full=0, out_valid=0, in_ready=1. Storage array is not reset. out_data is don't-care while out_valid=0.
- Push: occurs when in_valid && in_ready. Writes mem[wr_ptr]; wr_ptr advances.
- Pop: occurs when out_valid && out_ready. rd_ptr advances.
- Pointer wrap: each pointer goes from DEPTH-1 to 0, explicitly compared, not by natural overflow, so non-power-of-two DEPTH is correct.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- Flags full, empty, in_ready and out_valid are decoded combinationally from registered count. No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- out_data = mem[rd_ptr], combinational read of the registered array (FWFT).
- Latency: a word pushed at edge N is on out_data with out_valid=1 after edge N. It is poppable in cycle N+1 at the earliest, so minimum latency is 1 cycle.
- Full: in_ready=0, no write occurs. A simultaneous pop still occurs; in_ready rises the following cycle. No write-through when full.
- Empty: out_valid=0 and out_ready is ignored. A simultaneous push occurs and out_valid rises next cycle. No read-through when empty.
- Overflow: set on any cycle with in_valid=1 and full=1. It holds until RST_N or clear. Data is not written.
- clear: at the next edge, pointers, count and overflow return to 0, and any push or pop in that cycle is discarded.
- Reset mid-operation: all contents are lost, outputs go immediately to reset values, and operation resumes normally after deassertion.
- Steady state: with both sides always valid/ready, throughput is 1 word/cycle.

Test Plan:
- Reset then idle (WIDTH=8, DEPTH=4) -> count=0, empty=1, full=0, out_valid=0, in_ready=1, overflow=0.
- Push 0x11,0x22,0x33,0x44 on consecutive cycles, out_ready=0 -> count 1,2,3,4; full=1 and in_ready=0 after the 4th edge; out_data=0x11 from the cycle after the first push.
- Full, in_valid=1 with 0x55 and out_ready=1 for one cycle -> 0x11 popped, 0x55 not written, overflow=1, count=3. Drain order 0x22,0x33,0x44, then empty=1.
- Continuous streaming of 0x00..0x0F with both sides asserted -> output order identical, count stays at 1, pointers wrap several times with no drop or duplicate. Repeat with DEPTH=3 and DEPTH=5 to check the non-power-of-two wrap.
- Empty with in_valid=1 and out_ready=1 -> push only, pop suppressed; next cycle count=1 and out_valid=1.
- Fill to 2 entries, then pulse clear concurrently with a push and a pop -> next cycle count=0 and empty=1. Separately, assert RST_N low mid-stream -> all outputs return to reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/ansi_param_fifo.sv
// ansi_param_fifo: first-word-fall-through FIFO with valid/ready on both sides,
// occupancy count, sticky overflow flag and synchronous flush.
module ansi_param_fifo #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              push, pop;

    // Flags come only from the registered count, so no ready/valid feed-through.
    assign full      = count == CNT_W'(DEPTH);
    assign empty     = count == '0;
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push && !clear)
            mem[wr_ptr] <= in_data;
    end

    // Explicit wrap compare keeps non-power-of-two depths correct.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (in_valid && full)
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ansi_param_fifo.sv
// tb_ansi_param_fifo: directed checks of the FWFT FIFO at DEPTH 4, 3 and 5.
module tb_ansi_param_fifo;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    int         checks = 0;
    int         errors = 0;

    logic [7:0] od4, od3, od5;
    logic       ir4, ir3, ir5, ov4, ov3, ov5, fu4, fu3, fu5, em4, em3, em5, of4, of3, of5;
    logic [2:0] c4, c3, c5;

    always #5 CLK = ~CLK;

    ansi_param_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir4), .out_data(od4), .out_valid(ov4), .out_ready(out_ready),
        .count(c4), .full(fu4), .empty(em4), .overflow(of4));
    ansi_param_fifo #(.WIDTH(8), .DEPTH(3)) dut3 (
        .CLK(CLK), .RST_N(RST_N), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir3), .out_data(od3), .out_valid(ov3), .out_ready(out_ready),
        .count(c3[1:0]), .full(fu3), .empty(em3), .overflow(of3));
    ansi_param_fifo #(.WIDTH(8), .DEPTH(5)) dut5 (
        .CLK(CLK), .RST_N(RST_N), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir5), .out_data(od5), .out_valid(ov5), .out_ready(out_ready),
        .count(c5), .full(fu5), .empty(em5), .overflow(of5));
    assign c3[2] = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_count", c4, 0);
        chk("rst_empty", em4, 1);
        chk("rst_full", fu4, 0);
        chk("rst_out_valid", ov4, 0);
        chk("rst_in_ready", ir4, 1);
        chk("rst_overflow", of4, 0);
        RST_N = 1'b1;
        step();
        chk("idle_count", c4, 0);

        for (int i = 0; i < 4; i++) begin
            in_data = 8'h11 * (i + 1);
            in_valid = 1'b1;
            step();
            chk("fill_count", c4, i + 1);
            chk("fill_head", od4, 8'h11);
            chk("fill_out_valid", ov4, 1);
        end
        chk("fill_full", fu4, 1);
        chk("fill_in_ready", ir4, 0);
        chk("fill_overflow", of4, 0);

        in_data = 8'h55;
        out_ready = 1'b1;
        step();
        chk("ovf_flag", of4, 1);
        chk("ovf_count", c4, 3);
        chk("ovf_head", od4, 8'h22);
        chk("ovf_in_ready", ir4, 1);
        in_valid = 1'b0;
        step();
        chk("drain_head33", od4, 8'h33);
        step();
        chk("drain_head44", od4, 8'h44);
        chk("drain_count1", c4, 1);
        step();
        chk("drain_empty", em4, 1);
        chk("drain_count0", c4, 0);
        chk("ovf_sticky", of4, 1);

        in_data = 8'h66;
        in_valid = 1'b1;
        step();
        chk("empty_pp_count", c4, 1);
        chk("empty_pp_valid", ov4, 1);
        chk("empty_pp_data", od4, 8'h66);
        in_valid = 1'b0;
        step();
        chk("empty_pp_drain", c4, 0);

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hA1;
        step();
        in_data = 8'hA2;
        step();
        chk("clr_pre_count", c4, 2);
        in_data = 8'hA3;
        out_ready = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("clr_count", c4, 0);
        chk("clr_empty", em4, 1);
        chk("clr_overflow", of4, 0);
        chk("clr3_count", c3, 0);
        chk("clr5_count", c5, 0);
        step();
        chk("clr_hold", c4, 0);

        in_data = 8'h00;
        in_valid = 1'b1;
        step();
        for (int i = 1; i < 16; i++) begin
            in_data = 8'(i);
            out_ready = 1'b1;
            chk("stream4_head", od4, i - 1);
            chk("stream3_head", od3, i - 1);
            chk("stream5_head", od5, i - 1);
            step();
            chk("stream4_count", c4, 1);
            chk("stream3_count", c3, 1);
            chk("stream5_count", c5, 1);
        end
        in_valid = 1'b0;
        chk("stream4_last", od4, 8'h0F);
        chk("stream3_last", od3, 8'h0F);
        chk("stream5_last", od5, 8'h0F);
        step();
        chk("stream4_empty", em4, 1);
        chk("stream3_empty", em3, 1);
        chk("stream5_empty", em5, 1);

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hB1;
        step();
        in_data = 8'hB2;
        step();
        chk("mid_pre_count", c4, 2);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_count", c4, 0);
        chk("mid_rst_empty", em4, 1);
        chk("mid_rst_full", fu4, 0);
        chk("mid_rst_out_valid", ov4, 0);
        chk("mid_rst_in_ready", ir4, 1);
        chk("mid_rst_overflow", of4, 0);
        #2;
        RST_N = 1'b1;
        in_data = 8'h77;
        step();
        chk("post_rst_count", c4, 1);
        chk("post_rst_data", od4, 8'h77);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post_rst_empty", em4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
